// File: rtl/lcd_pixel_unpacker.sv
// rtl/lcd_pixel_unpacker.sv - unpacks 64-bit pixel-FIFO beats into 16-bit RGB565 pixels
//
// Sits in the LCD clock domain between the pixel FIFO and the LCD timing
// generator. Each 64-bit beat holds up to four RGB565 pixels, with the first
// pixel in [63:48]. The pixels go out one per cycle. Frame markers (SOP/EOP)
// and the EOP beat's empty count are preserved.
//
// Build option: define LCD_PIXEL_UNPACKER_SWAP_EN to byte-swap every emitted
// pixel. Use it for little-endian frame buffers.
//
// Ports:
//   clock, reset                   pixel clock; asynchronous active-high reset
//   avalonst_sink_*                beat input, ready latency 1
//                                  (data 64, empty 3, sop, eop, valid, ready)
//   avalonst_source_*              pixel output, ready latency 0
//                                  (data 16, sop, eop, valid, ready)
//   underflow_count                saturating count of starved in-frame cycles
//   protocol_error                 sticky; cleared only by reset
module lcd_pixel_unpacker (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] avalonst_sink_data,
   input  logic [2:0]  avalonst_sink_empty,
   input  logic        avalonst_sink_startofpacket,
   input  logic        avalonst_sink_endofpacket,
   input  logic        avalonst_sink_valid,
   output logic        avalonst_sink_ready,
   output logic [15:0] avalonst_source_data,
   output logic        avalonst_source_startofpacket,
   output logic        avalonst_source_endofpacket,
   output logic        avalonst_source_valid,
   input  logic        avalonst_source_ready,
   output logic [15:0] underflow_count,
   output logic        protocol_error
);

   typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  empty;
      logic        sop;
      logic        eop;
   } beat_t;

   state_t      state_q, state_d;
   beat_t       head_q, tail_q, in_beat;
   logic [1:0]  occupancy;
   logic [1:0]  idx_q, last_idx;
   logic        ready_d1, run_q;
   logic        accept, drop, xfer, pop, frame_err, odd_err;
   logic [15:0] pix, pix_out;

   assign in_beat = {avalonst_sink_data, avalonst_sink_empty,
                     avalonst_sink_startofpacket, avalonst_sink_endofpacket};

   // The ready term counts a beat that may still be in flight from last
   // cycle's ready. The buffer therefore can never overflow. run_q keeps
   // ready low until the first clock edge after reset.
   assign avalonst_sink_ready = run_q && ((occupancy + {1'b0, ready_d1}) < 2'd2);
   assign accept = avalonst_sink_valid && ready_d1;
   assign drop   = avalonst_sink_valid && !ready_d1;

   // The pixel count for an EOP beat is 4 - (empty >> 1). The last index is one less.
   assign last_idx = head_q.eop ? (2'd3 - head_q.empty[2:1]) : 2'd3;

   assign avalonst_source_valid = (occupancy != 2'd0);
   assign xfer = avalonst_source_valid && avalonst_source_ready;
   assign pop  = xfer && (idx_q == last_idx);

   always_comb begin
      pix = head_q.data[63:48];
      case (idx_q)
         2'd1:    pix = head_q.data[47:32];
         2'd2:    pix = head_q.data[31:16];
         2'd3:    pix = head_q.data[15:0];
         default: pix = head_q.data[63:48];
      endcase
   end

`ifdef LCD_PIXEL_UNPACKER_SWAP_EN
   assign pix_out = {pix[7:0], pix[15:8]};
`else
   assign pix_out = pix;
`endif

   // The source is driven only from the registered head entry and index.
   // A stalled pixel holds until it is taken. Data is forced to zero when
   // valid is low, so reset clears every output.
   assign avalonst_source_data          = avalonst_source_valid ? pix_out : 16'h0000;
   assign avalonst_source_startofpacket = avalonst_source_valid && head_q.sop && (idx_q == 2'd0);
   assign avalonst_source_endofpacket   = avalonst_source_valid && head_q.eop && (idx_q == last_idx);

   // Framing is judged when a beat's first pixel leaves. At that point the
   // state reflects every pixel emitted before it.
   assign frame_err = xfer && (idx_q == 2'd0) &&
                      ((head_q.sop && (state_q == IN_PKT)) || (!head_q.sop && (state_q == IDLE)));
   assign odd_err   = xfer && (idx_q == 2'd0) && head_q.eop && head_q.empty[0];

   always_comb begin
      state_d = state_q;
      if (xfer) begin
         if (head_q.sop && head_q.eop)
            state_d = IDLE;          // a whole frame in one beat never leaves IDLE
         else if (avalonst_source_endofpacket)
            state_d = IDLE;
         else if (avalonst_source_startofpacket)
            state_d = IN_PKT;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         head_q          <= '0;
         tail_q          <= '0;
         occupancy       <= 2'd0;
         idx_q           <= 2'd0;
         ready_d1        <= 1'b0;
         run_q           <= 1'b0;
         underflow_count <= 16'h0000;
         protocol_error  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_d1 <= avalonst_sink_ready;
         run_q    <= 1'b1;

         if (pop)
            head_q <= tail_q;
         if (accept) begin
            // With one entry left after a pop, the new beat becomes the head.
            if ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop))
               head_q <= in_beat;
            else
               tail_q <= in_beat;
         end
         occupancy <= occupancy + {1'b0, accept} - {1'b0, pop};

         if (pop)
            idx_q <= 2'd0;
         else if (xfer)
            idx_q <= idx_q + 2'd1;

         if ((state_q == IN_PKT) && avalonst_source_ready && !avalonst_source_valid &&
             (underflow_count != 16'hFFFF))
            underflow_count <= underflow_count + 16'h0001;

         if (drop || frame_err || odd_err)
            protocol_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// tb/tb_lcd_pixel_unpacker.sv - directed self-checking bench for lcd_pixel_unpacker
`timescale 1ns/1ps
module tb_lcd_pixel_unpacker;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] sink_data = '0;
   logic [2:0]  sink_empty = '0;
   logic        sink_sop = 1'b0;
   logic        sink_eop = 1'b0;
   logic        sink_valid = 1'b0;
   logic        sink_ready;
   logic [15:0] src_data;
   logic        src_sop, src_eop, src_valid;
   logic        src_ready = 1'b1;
   logic [15:0] underflow_count;
   logic        protocol_error;

   int checks = 0;
   int errors = 0;
   int base = 0;

   // written only by the monitor
   logic [17:0] got [$];
   int          hold_viol = 0;
   int          stall_cnt = 0;
   int          full_cnt = 0;
   int          full_viol = 0;
   logic        prev_stall = 1'b0;
   logic [17:0] prev_out = '0;

   always #5 clock = ~clock;

   lcd_pixel_unpacker dut (
      .clock                         (clock),
      .reset                         (reset),
      .avalonst_sink_data            (sink_data),
      .avalonst_sink_empty           (sink_empty),
      .avalonst_sink_startofpacket   (sink_sop),
      .avalonst_sink_endofpacket     (sink_eop),
      .avalonst_sink_valid           (sink_valid),
      .avalonst_sink_ready           (sink_ready),
      .avalonst_source_data          (src_data),
      .avalonst_source_startofpacket (src_sop),
      .avalonst_source_endofpacket   (src_eop),
      .avalonst_source_valid         (src_valid),
      .avalonst_source_ready         (src_ready),
      .underflow_count               (underflow_count),
      .protocol_error                (protocol_error)
   );

   function automatic logic [15:0] sw(input logic [15:0] p);
`ifdef LCD_PIXEL_UNPACKER_SWAP_EN
      return {p[7:0], p[15:8]};
`else
      return p;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [63:0] d, input logic [2:0] e, input logic s, input logic p);
      sink_data  = d;
      sink_empty = e;
      sink_sop   = s;
      sink_eop   = p;
      sink_valid = 1'b1;
   endtask

   // Present one beat in the cycle after ready was seen high.
   task automatic send(input logic [63:0] d, input logic [2:0] e, input logic s, input logic p);
      int n = 0;
      while (!sink_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_timeout", 32'(n < 50), 32'd1);
      tick();
      drive(d, e, s, p);
      tick();
      sink_valid = 1'b0;
   endtask

   task automatic expect_pix(input int i, input logic [15:0] d, input logic s, input logic e);
      if (base + i < got.size())
         chk($sformatf("pix%0d", i), {14'd0, got[base + i]}, {14'd0, s, e, sw(d)});
      else
         chk($sformatf("pix%0d_missing", i), 32'(got.size() - base), 32'(i + 1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            stall_cnt++;
            if ({src_valid, src_sop, src_eop, src_data} !== {1'b1, prev_out})
               hold_viol++;
         end
         if (dut.occupancy == 2'd2) begin
            full_cnt++;
            if (sink_ready)
               full_viol++;
         end
         if (src_valid && src_ready)
            got.push_back({src_sop, src_eop, src_data});
         prev_stall = src_valid && !src_ready;
         prev_out   = {src_sop, src_eop, src_data};
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_src", {11'd0, src_valid, src_sop, src_eop, src_data, sink_ready, protocol_error}, 32'd0);
      chk("rst_underflow", 32'(underflow_count), 32'd0);
      reset = 1'b0;
      chk("ready_at_release", 32'(sink_ready), 32'd0);
      tick();
      chk("ready_first_cycle", 32'(sink_ready), 32'd1);

      // single SOP+EOP beat, latency and order
      tick();
      drive(64'h1111_2222_3333_4444, 3'd0, 1'b1, 1'b1);
      tick();
      sink_valid = 1'b0;
      chk("t1_p0", {13'd0, src_valid, src_sop, src_eop, src_data}, {13'd0, 3'b110, sw(16'h1111)});
      tick();
      chk("t1_p1", {13'd0, src_valid, src_sop, src_eop, src_data}, {13'd0, 3'b100, sw(16'h2222)});
      tick();
      chk("t1_p2", {13'd0, src_valid, src_sop, src_eop, src_data}, {13'd0, 3'b100, sw(16'h3333)});
      tick();
      chk("t1_p3", {13'd0, src_valid, src_sop, src_eop, src_data}, {13'd0, 3'b101, sw(16'h4444)});
      tick();
      chk("t1_idle", {15'd0, src_valid, src_data}, 32'd0);
      chk("t1_perr", 32'(protocol_error), 32'd0);

      // three-beat frame, last beat empty=4
      base = got.size();
      send(64'h0001_0002_0003_0004, 3'd0, 1'b1, 1'b0);
      send(64'h0005_0006_0007_0008, 3'd0, 1'b0, 1'b0);
      send(64'h0009_000A_0BAD_0BAD, 3'd4, 1'b0, 1'b1);
      repeat (12) tick();
      chk("t2_count", 32'(got.size() - base), 32'd10);
      for (int i = 0; i < 10; i++)
         expect_pix(i, 16'(i + 1), i == 0, i == 9);
      chk("t2_perr", 32'(protocol_error), 32'd0);
      chk("t2_underflow", 32'(underflow_count), 32'd0);

      // eight-beat frame with the consumer ready toggling every cycle
      base = got.size();
      fork
         begin
            for (int b = 0; b < 8; b++)
               send({16'(16'h0100 + 4*b), 16'(16'h0101 + 4*b),
                     16'(16'h0102 + 4*b), 16'(16'h0103 + 4*b)}, 3'd0, b == 0, b == 7);
         end
         begin
            repeat (100) begin
               src_ready = ~src_ready;
               tick();
            end
         end
      join
      src_ready = 1'b1;
      repeat (10) tick();
      chk("t3_count", 32'(got.size() - base), 32'd32);
      for (int i = 0; i < 32; i++)
         expect_pix(i, 16'(16'h0100 + i), i == 0, i == 31);
      chk("t3_stalls_seen", 32'(stall_cnt != 0), 32'd1);
      chk("t3_hold_viol", 32'(hold_viol), 32'd0);
      chk("t3_full_seen", 32'(full_cnt != 0), 32'd1);
      chk("t3_ready_when_full", 32'(full_viol), 32'd0);
      chk("t3_perr", 32'(protocol_error), 32'd0);

      // five starved cycles inside a frame, none while idle
      do_reset();
      send(64'h0A01_0A02_0A03_0A04, 3'd0, 1'b1, 1'b0);
      repeat (8) tick();
      drive(64'h0B01_0B02_0B03_0B04, 3'd0, 1'b0, 1'b1);
      tick();
      sink_valid = 1'b0;
      chk("t4_resume", {15'd0, src_valid, src_data}, {15'd0, 1'b1, sw(16'h0B01)});
      chk("t4_underflow", 32'(underflow_count), 32'd5);
      repeat (15) tick();
      chk("t4_underflow_idle", 32'(underflow_count), 32'd5);
      chk("t4_perr", 32'(protocol_error), 32'd0);

      // valid without prior ready: dropped
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      base = got.size();
      drive(64'hDEAD_BEEF_DEAD_BEEF, 3'd0, 1'b1, 1'b1);
      tick();
      sink_valid = 1'b0;
      chk("t5a_perr", 32'(protocol_error), 32'd1);
      repeat (6) tick();
      chk("t5a_dropped", 32'(got.size() - base), 32'd0);
      chk("t5a_src_valid", 32'(src_valid), 32'd0);

      // odd empty=3 yields three pixels
      do_reset();
      chk("t5b_perr_cleared", 32'(protocol_error), 32'd0);
      base = got.size();
      send(64'hAAAA_BBBB_CCCC_DDDD, 3'd3, 1'b1, 1'b1);
      repeat (8) tick();
      chk("t5b_count", 32'(got.size() - base), 32'd3);
      expect_pix(0, 16'hAAAA, 1'b1, 1'b0);
      expect_pix(1, 16'hBBBB, 1'b0, 1'b0);
      expect_pix(2, 16'hCCCC, 1'b0, 1'b1);
      chk("t5b_perr", 32'(protocol_error), 32'd1);

      // reset mid-beat, then a clean frame
      do_reset();
      send(64'h5555_6666_7777_8888, 3'd0, 1'b1, 1'b0);
      tick();
      chk("t6_mid_beat", {15'd0, src_valid, src_data}, {15'd0, 1'b1, sw(16'h6666)});
      reset = 1'b1;
      #1;
      chk("t6_async_clear", {11'd0, src_valid, src_sop, src_eop, src_data, sink_ready, protocol_error}, 32'd0);
      chk("t6_underflow_clear", 32'(underflow_count), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      base = got.size();
      send(64'h1234_5678_9ABC_DEF0, 3'd0, 1'b1, 1'b1);
      repeat (8) tick();
      chk("t6_count", 32'(got.size() - base), 32'd4);
      expect_pix(0, 16'h1234, 1'b1, 1'b0);
      expect_pix(1, 16'h5678, 1'b0, 1'b0);
      expect_pix(2, 16'h9ABC, 1'b0, 1'b0);
      expect_pix(3, 16'hDEF0, 1'b0, 1'b1);
      chk("t6_perr", 32'(protocol_error), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
